// File: rtl/tdm_fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR family: FSM states,
// a constant clog2 helper and the default 15-tap halfband coefficient set.
package tdm_fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Unique halfband coefficients, outer tap first, centre tap last (1s17).
  function automatic int default_coef(input int idx);
    case (idx)
      0:       return -174;
      1:       return 0;
      2:       return 1637;
      3:       return 0;
      4:       return -7962;
      5:       return 0;
      6:       return 39267;
      7:       return 65536;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/tdm_fir_round_sat.sv
// Round-half-up, arithmetic shift and width reduction from accumulator to sample.
// Define FIR_SAT_EN to clamp instead of wrapping the result to WIDTH bits.
module tdm_fir_round_sat
  import tdm_fir_pkg::*;
#(
  parameter int ACC_W     = 40,
  parameter int WIDTH     = 18,
  parameter int OUT_SHIFT = 17
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [WIDTH-1:0] y
);

  // One guard bit keeps the rounding add from overflowing at full scale.
  localparam int RW = ACC_W + 1;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] sum;
    half = '0;
    half[OUT_SHIFT-1] = 1'b1;
    sum = RW'(a) + half;
    return sum >>> OUT_SHIFT;
  endfunction

`ifdef FIR_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [RW-1:0] r);
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    hi = '0;
    hi[WIDTH-2:0] = '1;
    lo = '1;
    lo[WIDTH-2:0] = '0;
    if (r > hi)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (r < lo) return {1'b1, {(WIDTH-1){1'b0}}};
    else             return WIDTH'(r);
  endfunction

  always_comb y = saturate(round_shift(acc));
`else
  always_comb y = WIDTH'(round_shift(acc));
`endif

endmodule

// File: rtl/tdm_sym_fir.sv
// Folded symmetric odd-length FIR: one pre-adder and one multiplier shared over
// (LENGTH+1)/2 cycles per sample. Optional output clamping via FIR_SAT_EN.
module tdm_sym_fir
  import tdm_fir_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int COEF_W    = 18,
  parameter int LENGTH    = 15,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 17
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [WIDTH-1:0]               x_in,
  input  logic                                  coef_we,
  input  logic [clog2((LENGTH+1)/2)-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0]              coef_data,
  output logic signed [WIDTH-1:0]               y_out,
  output logic                                  y_valid,
  output logic                                  overrun
);

  localparam int NUNIQ  = (LENGTH + 1) / 2;
  localparam int KW     = clog2(NUNIQ);
  localparam int PRE_W  = WIDTH + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  // Coefficients are stored XOR'd with their defaults so that registers powering
  // up at zero read back as the halfband set without any reset or init logic.
  function automatic logic signed [COEF_W-1:0] dflt(input int idx);
    return (LENGTH == 15) ? COEF_W'(default_coef(idx)) : '0;
  endfunction

  fir_state_e state, state_nx;
  logic [KW-1:0] k;
  logic          drain_cnt;
  logic          accept;

  logic signed [WIDTH-1:0]  x_dl   [LENGTH];
  logic signed [COEF_W-1:0] coef_q [NUNIQ];

  logic signed [WIDTH-1:0]  xa_p0, xb_p0;
  logic signed [COEF_W-1:0] h_p0;
  logic signed [PRE_W-1:0]  pre_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0, first_p0;

  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1, first_p1;

  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [WIDTH-1:0]  y_rs;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MAC;
      MAC:     if (k == KW'(NUNIQ - 1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    y_valid  = (state == OUT);
    vld_p0   = (state == MAC);
    accept   = in_ready && in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      drain_cnt <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      k         <= (state == MAC) ? k + KW'(1) : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (in_valid && !in_ready) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LENGTH; i++) x_dl[i] <= '0;
    end else if (accept) begin
      x_dl[0] <= x_in;
      for (int i = LENGTH - 1; i > 0; i--) x_dl[i] <= x_dl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUNIQ; i++)
      if (coef_we && coef_addr == KW'(i)) coef_q[i] <= coef_data ^ dflt(i);
  end

  // Stage 0: tap select, symmetric pre-add and multiply (centre tap used once)
  always_comb begin
    xa_p0 = '0;
    xb_p0 = '0;
    h_p0  = '0;
    for (int i = 0; i < NUNIQ; i++) begin
      if (k == KW'(i)) begin
        xa_p0 = x_dl[i];
        xb_p0 = x_dl[LENGTH-1-i];
        h_p0  = coef_q[i] ^ dflt(i);
      end
    end
    if (k == KW'(NUNIQ - 1)) pre_p0 = PRE_W'(xa_p0);
    else                     pre_p0 = PRE_W'(xa_p0) + PRE_W'(xb_p0);
    prod_p0  = PROD_W'(pre_p0) * PROD_W'(h_p0);
    first_p0 = (k == '0);
  end

  // Stage 1: registered product
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p1  <= '0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      prod_p1  <= prod_p0;
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
    end
  end

  // Stage 2: accumulate, first product of a sample loads instead of adding
  always_ff @(posedge clk) begin
    if (reset)       acc_p2 <= '0;
    else if (vld_p1) acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
  end

  tdm_fir_round_sat #(
    .ACC_W     (ACC_W),
    .WIDTH     (WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc (acc_p2),
    .y   (y_rs)
  );

  // Output register: loaded on the last drain cycle so it is fresh during OUT
  always_ff @(posedge clk) begin
    if (reset)                            y_out <= '0;
    else if (state == DRAIN && drain_cnt) y_out <= y_rs;
  end

endmodule

// File: tb/tb_tdm_sym_fir.sv
// Directed bench for tdm_sym_fir: impulse, DC, handshake, coefficient reload,
// overflow and mid-computation reset, with hand-computed expected outputs.
module tb_tdm_sym_fir;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] x_in = '0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic signed [17:0] y_out;
  logic               y_valid;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdm_sym_fir dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 18'(data);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offers one sample, waits for its y_valid, checks latency and strobe width.
  task automatic send(input string tag, input int x, output int y);
    int lat;
    for (int w = 0; w < 40 && !in_ready; w++) @(negedge clk);
    in_valid = 1'b1;
    x_in     = 18'(x);
    lat      = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!y_valid && lat < 30);
    y = int'(y_out);
    chk({tag, "_latency"}, lat, 11);
    @(negedge clk);
    chk({tag, "_strobe_width"}, longint'(y_valid), 0);
    chk({tag, "_hold"}, longint'(y_out), longint'(y));
  endtask

  initial begin
    int y;
    int acc_cnt, vld_cnt, last_acc;
    int imp_exp [15] = '{-87, 0, 819, 0, -3981, 0, 19634, 32768,
                          19634, 0, -3981, 0, 819, 0, -87};
    int dflt [8] = '{-174, 0, 1637, 0, -7962, 0, 39267, 65536};

    @(negedge clk);
    do_reset();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_y_valid",  longint'(y_valid),  0);
    chk("rst_overrun",  longint'(overrun),  0);
    chk("rst_y_out",    longint'(y_out),    0);

    // Impulse with the default halfband set
    for (int i = 0; i < 8; i++) write_coef(i, dflt[i]);
    for (int n = 0; n < 15; n++) begin
      send("imp", (n == 0) ? 65536 : 0, y);
      chk($sformatf("imp_y%0d", n), y, imp_exp[n]);
    end

    // DC gain of the default set is exactly unity
    for (int n = 0; n < 200; n++) send("dc", 1000, y);
    n_tests++;
    assert (y >= 999 && y <= 1001)
      else begin
        n_fail++;
        $error("FAIL dc_settled: observed %0d expected 1000 +/-1", y);
      end

    // Continuous in_valid: one accept per 12 cycles, the rest dropped
    do_reset();
    acc_cnt  = 0;
    vld_cnt  = 0;
    last_acc = -1;
    x_in     = '0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready) begin
        if (last_acc >= 0) chk($sformatf("hs_spacing_c%0d", c), c - last_acc, 12);
        last_acc = c;
        acc_cnt++;
      end
      if (y_valid) vld_cnt++;
      if (c == 1) chk("hs_overrun_before_drop", longint'(overrun), 0);
      if (c == 2) chk("hs_overrun_after_drop",  longint'(overrun), 1);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("hs_accepts", acc_cnt, 5);
    chk("hs_y_valids", vld_cnt, 5);
    chk("hs_overrun_sticky", longint'(overrun), 1);
    for (int c = 0; c < 15; c++) @(negedge clk);

    // Reloaded coefficients: centre tap near unity, the rest zero
    do_reset();
    for (int i = 0; i < 7; i++) write_coef(i, 0);
    write_coef(7, 131071);
    for (int n = 0; n < 15; n++) begin
      send("reload", (n == 0) ? 1000 : 0, y);
      chk($sformatf("reload_y%0d", n), y, (n == 7) ? 1000 : 0);
    end

    // Full-scale input against full-scale coefficients
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(i, 131071);
    for (int n = 0; n < 16; n++) send("ovf", 131071, y);
`ifdef FIR_SAT_EN
    chk("ovf_settled", y, 131071);
`else
    chk("ovf_settled", y, 131042);
`endif

    // Reset three cycles into a computation abandons the sample
    for (int i = 0; i < 8; i++) write_coef(i, dflt[i]);
    in_valid = 1'b1;
    x_in     = 18'(65536);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_y_out",    longint'(y_out),    0);
    vld_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (y_valid) vld_cnt++;
      @(negedge clk);
    end
    chk("midrst_no_y_valid", vld_cnt, 0);
    send("post", 65536, y);
    chk("post_y0", y, -87);
    send("post", 0, y);
    chk("post_y1", y, 0);
    send("post", 0, y);
    chk("post_y2", y, 819);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
